// File: rtl/mem_align_unit.sv
// Memory-stage load/store unit: lane steering, byte enables, two-beat split of misaligned accesses.
// Optional macro MISALIGN_TRAP_EN: trap split accesses with addr_err_M instead of running two beats.
module mem_align_unit #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_M,
    input  logic              we_M,
    input  logic [1:0]        size_M,
    input  logic              sign_extend_en_M,
    input  logic [ADDR_W-1:0] addr_M,
    input  logic [DATA_W-1:0] write_data_M,
    output logic              stall_M,
    output logic              done_M,
    output logic [DATA_W-1:0] data_out_M,
    output logic              addr_err_M,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W/8-1:0] bus_byte_en,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic              bus_ack,
    input  logic [DATA_W-1:0] bus_rdata
);

    localparam int NB    = DATA_W / 8;
    localparam int OFS_W = $clog2(NB);

    // state | meaning
    // IDLE  | waiting for req_M; operands captured on request
    // BEAT1 | first aligned bus beat outstanding
    // BEAT2 | overflow beat of a split access outstanding
    // RESP  | done_M pulse, load result on data_out_M
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BEAT1 = 2'd1,
        BEAT2 = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic [1:0]        size_eff;
    logic [OFS_W:0]    bytes_in;
    logic [OFS_W-1:0]  off_in;
    logic [2*NB-1:0]   lane_mask;
    logic [2*NB-1:0]   lane_shift;
    logic [NB-1:0]     en1_in;
    logic [NB-1:0]     en2_in;
    logic              split_in;
    logic              trap_in;
    logic [DATA_W-1:0] steered_in;
    logic [ADDR_W-1:0] base_in;

    logic              we_q;
    logic              sext_q;
    logic [OFS_W-1:0]  off_q;
    logic [OFS_W:0]    bytes_q;
    logic [NB-1:0]     en2_q;
    logic              split_q;
    logic [DATA_W-1:0] rd1_q;
`ifdef MISALIGN_TRAP_EN
    logic              err_q;
`endif

    logic [DATA_W-1:0] rd_lo;
    logic [DATA_W-1:0] rd_shift;
    logic [DATA_W-1:0] load_val;
    logic              sign_bit;
    int                nbits;

    always_comb begin
        // a doubleword request on a 32-bit bus is served as a word
        size_eff   = (int'(size_M) > OFS_W) ? 2'(OFS_W) : size_M;
        bytes_in   = {{OFS_W{1'b0}}, 1'b1} << size_eff;
        off_in     = addr_M[OFS_W-1:0];
        lane_mask  = '0;
        for (int i = 0; i < NB; i++) begin
            lane_mask[i] = (i < int'(bytes_in));
        end
        lane_shift = lane_mask << off_in;
        en1_in     = lane_shift[NB-1:0];
        en2_in     = lane_shift[2*NB-1:NB];
        split_in   = |en2_in;
        steered_in = DATA_W'(({write_data_M, write_data_M} << {off_in, 3'b000}) >> DATA_W);
        base_in    = {addr_M[ADDR_W-1:OFS_W], {OFS_W{1'b0}}};
`ifdef MISALIGN_TRAP_EN
        trap_in    = split_in;
`else
        trap_in    = 1'b0;
`endif
    end

    // beat-1 lanes sit in the low half of the window, overflow lanes in the high half
    always_comb begin
        rd_lo    = (state == BEAT2) ? rd1_q : bus_rdata;
        rd_shift = DATA_W'({bus_rdata, rd_lo} >> {off_q, 3'b000});
        nbits    = 8 * int'(bytes_q);
        sign_bit = 1'b0;
        for (int k = 0; k < NB; k++) begin
            if (int'(bytes_q) == k + 1) sign_bit = rd_shift[8*k+7];
        end
        load_val = '0;
        for (int i = 0; i < DATA_W; i++) begin
            load_val[i] = (i < nbits) ? rd_shift[i] : (sext_q & sign_bit);
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req_M) state_nxt = trap_in ? RESP : BEAT1;
            BEAT1:   if (bus_ack) state_nxt = split_q ? BEAT2 : RESP;
            BEAT2:   if (bus_ack) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            bus_req     <= 1'b0;
            bus_we      <= 1'b0;
            bus_addr    <= '0;
            bus_byte_en <= '0;
            bus_wdata   <= '0;
            data_out_M  <= '0;
            we_q        <= 1'b0;
            sext_q      <= 1'b0;
            off_q       <= '0;
            bytes_q     <= '0;
            en2_q       <= '0;
            split_q     <= 1'b0;
            rd1_q       <= '0;
`ifdef MISALIGN_TRAP_EN
            err_q       <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (req_M) begin
                        we_q    <= we_M;
                        sext_q  <= sign_extend_en_M;
                        off_q   <= off_in;
                        bytes_q <= bytes_in;
                        en2_q   <= en2_in;
                        split_q <= split_in;
`ifdef MISALIGN_TRAP_EN
                        err_q   <= trap_in;
`endif
                        if (!trap_in) begin
                            bus_req     <= 1'b1;
                            bus_we      <= we_M;
                            bus_addr    <= base_in;
                            bus_byte_en <= en1_in;
                            bus_wdata   <= steered_in;
                        end
                    end
                end
                BEAT1: begin
                    if (bus_ack) begin
                        rd1_q <= bus_rdata;
                        if (split_q) begin
                            bus_addr    <= bus_addr + ADDR_W'(NB);
                            bus_byte_en <= en2_q;
                        end else begin
                            bus_req <= 1'b0;
                            bus_we  <= 1'b0;
                            if (!we_q) data_out_M <= load_val;
                        end
                    end
                end
                BEAT2: begin
                    if (bus_ack) begin
                        bus_req <= 1'b0;
                        bus_we  <= 1'b0;
                        if (!we_q) data_out_M <= load_val;
                    end
                end
                default: ;
            endcase
        end
    end

    // gated by reset_n so a pending req_M cannot hold the pipeline while in reset
    assign stall_M = reset_n & (((state == IDLE) & req_M) | (state == BEAT1) | (state == BEAT2));
    assign done_M  = (state == RESP);
`ifdef MISALIGN_TRAP_EN
    assign addr_err_M = (state == RESP) & err_q;
`else
    assign addr_err_M = 1'b0;
`endif

endmodule

// File: tb/tb_mem_align_unit.sv
// Scoreboard bench for mem_align_unit (DATA_W=32) with a small reactive bus model.
module tb_mem_align_unit;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        req_M = 1'b0;
    logic        we_M = 1'b0;
    logic [1:0]  size_M = 2'd0;
    logic        sign_extend_en_M = 1'b0;
    logic [31:0] addr_M = '0;
    logic [31:0] write_data_M = '0;
    logic        stall_M;
    logic        done_M;
    logic [31:0] data_out_M;
    logic        addr_err_M;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_byte_en;
    logic [31:0] bus_wdata;
    logic        bus_ack = 1'b0;
    logic [31:0] bus_rdata = '0;

    mem_align_unit #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset_n(reset_n), .req_M(req_M), .we_M(we_M), .size_M(size_M),
        .sign_extend_en_M(sign_extend_en_M), .addr_M(addr_M), .write_data_M(write_data_M),
        .stall_M(stall_M), .done_M(done_M), .data_out_M(data_out_M), .addr_err_M(addr_err_M),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_byte_en(bus_byte_en),
        .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a1;
        logic [3:0]  e1;
        logic [31:0] w1;
        logic [31:0] a2;
        logic [3:0]  e2;
        int          beats;
        int          lat;
        bit          bus_ok;
        bit          stall_ok;
        bit          pulse_ok;
        bit          saw_req;
        bit          err;
        logic [31:0] dout;
    } obs_t;

    typedef struct {
        logic [31:0] dout;
        int          lat;
    } exp_t;

    exp_t        sb_q[$];
    int          tests_run = 0;
    int          tests_failed = 0;
    logic [31:0] model_dout = '0;

    // issue one access, answer its beats after `waits` idle cycles each, record what was seen
    task automatic run_access(input bit we, input logic [1:0] size, input bit sx,
                              input logic [31:0] addr, input logic [31:0] wd,
                              input logic [31:0] rd1, input logic [31:0] rd2,
                              input int waits, output obs_t o);
        int waited;
        int b;
        bit done;
        o = '{default: 0};
        o.bus_ok = 1; o.stall_ok = 1; o.lat = -1;
        @(negedge clk);
        req_M = 1; we_M = we; size_M = size; sign_extend_en_M = sx; addr_M = addr; write_data_M = wd;
        #1;
        if (stall_M !== 1'b1) o.stall_ok = 0;
        waited = 0; b = 0; done = 0;
        for (int cyc = 1; cyc <= 30 && !done; cyc++) begin
            @(negedge clk); #1;
            bus_ack = 0;
            if (done_M === 1'b1) begin
                done = 1; o.lat = cyc; o.dout = data_out_M; o.err = addr_err_M;
                if (stall_M !== 1'b0) o.stall_ok = 0;
            end else begin
                if (stall_M !== 1'b1) o.stall_ok = 0;
                if (bus_req === 1'b1) begin
                    o.saw_req = 1;
                    if (waited == 0) begin
                        if (b == 0) begin o.a1 = bus_addr; o.e1 = bus_byte_en; o.w1 = bus_wdata; end
                        else begin o.a2 = bus_addr; o.e2 = bus_byte_en; end
                    end else if (bus_addr !== ((b == 0) ? o.a1 : o.a2) ||
                                 bus_byte_en !== ((b == 0) ? o.e1 : o.e2)) begin
                        o.bus_ok = 0;
                    end
                    if (bus_we !== we || bus_wdata !== o.w1) o.bus_ok = 0;
                    if (waited >= waits) begin
                        bus_ack = 1; bus_rdata = (b == 0) ? rd1 : rd2;
                        b++; o.beats = b; waited = 0;
                    end else begin
                        waited++;
                    end
                end
            end
        end
        req_M = 0; bus_ack = 0;
        @(negedge clk); #1;
        o.pulse_ok = (done_M === 1'b0) && (bus_req === 1'b0);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        #1;
        tests_run++;
        if ({bus_req, bus_we, done_M, stall_M, addr_err_M} !== 5'b0) begin
            tests_failed++;
            $display("FAIL reset_ctrl got %b want 00000", {bus_req, bus_we, done_M, stall_M, addr_err_M});
        end
        tests_run++;
        if ({bus_addr, bus_byte_en, bus_wdata, data_out_M} !== '0) begin
            tests_failed++;
            $display("FAIL reset_data got addr=%h en=%b wdata=%h dout=%h want all 0",
                     bus_addr, bus_byte_en, bus_wdata, data_out_M);
        end
        reset_n = 1;
    endtask

    task automatic test_aligned_store();
        obs_t o;
        exp_t e;
        sb_q.push_back('{model_dout, 2});
        run_access(1, 2'd2, 0, 32'h100, 32'hAABBCCDD, 32'h0, 32'h0, 0, o);
        tests_run++;
        if (o.a1 !== 32'h100 || o.e1 !== 4'b1111 || o.w1 !== 32'hAABBCCDD) begin
            tests_failed++;
            $display("FAIL store_word bus got addr=%h en=%b wdata=%h want 00000100 1111 aabbccdd", o.a1, o.e1, o.w1);
        end
        tests_run++;
        if (o.beats != 1 || !o.stall_ok || !o.pulse_ok || !o.bus_ok) begin
            tests_failed++;
            $display("FAIL store_word_ctrl got beats=%0d stall_ok=%0d pulse_ok=%0d bus_ok=%0d want 1 1 1 1",
                     o.beats, o.stall_ok, o.pulse_ok, o.bus_ok);
        end
        e = sb_q.pop_front();
        tests_run++;
        if (o.lat != e.lat || o.dout !== e.dout) begin
            tests_failed++;
            $display("FAIL store_word_done got lat=%0d dout=%h want lat=%0d dout=%h", o.lat, o.dout, e.lat, e.dout);
        end
    endtask

    task automatic test_byte_load();
        obs_t o;
        exp_t e;
        logic [31:0] want;
        for (int s = 1; s >= 0; s--) begin
            want = (s == 1) ? 32'hFFFFFF80 : 32'h00000080;
            sb_q.push_back('{want, 2});
            model_dout = want;
            run_access(0, 2'd0, s[0], 32'h103, 32'h0, 32'h80112233, 32'h0, 0, o);
            tests_run++;
            if (o.a1 !== 32'h100 || o.e1 !== 4'b1000 || o.beats != 1) begin
                tests_failed++;
                $display("FAIL byte_load_bus sx=%0d got addr=%h en=%b beats=%0d want 00000100 1000 1", s, o.a1, o.e1, o.beats);
            end
            e = sb_q.pop_front();
            tests_run++;
            if (o.lat != e.lat || o.dout !== e.dout) begin
                tests_failed++;
                $display("FAIL byte_load sx=%0d got lat=%0d dout=%h want lat=%0d dout=%h", s, o.lat, o.dout, e.lat, e.dout);
            end
        end
    endtask

    task automatic test_half_store();
        obs_t o;
        exp_t e;
        sb_q.push_back('{model_dout, 2});
        run_access(1, 2'd1, 0, 32'h102, 32'h0000BEEF, 32'h0, 32'h0, 0, o);
        tests_run++;
        if (o.e1 !== 4'b1100 || o.w1 !== 32'hBEEF0000 || o.beats != 1) begin
            tests_failed++;
            $display("FAIL half_store got en=%b wdata=%h beats=%0d want 1100 beef0000 1", o.e1, o.w1, o.beats);
        end
        e = sb_q.pop_front();
        tests_run++;
        if (o.lat != e.lat || o.dout !== e.dout) begin
            tests_failed++;
            $display("FAIL half_store_done got lat=%0d dout=%h want lat=%0d dout=%h", o.lat, o.dout, e.lat, e.dout);
        end
    endtask

    task automatic test_split_load();
        obs_t o;
        exp_t e;
        logic [31:0] t_addr [2] = '{32'h101, 32'h103};
        logic [1:0]  t_size [2] = '{2'd2, 2'd1};
        logic [31:0] t_rd1  [2] = '{32'h44332211, 32'hAB000000};
        logic [31:0] t_rd2  [2] = '{32'h88776655, 32'h000000CD};
        logic [3:0]  t_en1  [2] = '{4'b1110, 4'b1000};
        logic [31:0] t_res  [2] = '{32'h55443322, 32'hFFFFCDAB};
        for (int i = 0; i < 2; i++) begin
`ifdef MISALIGN_TRAP_EN
            sb_q.push_back('{model_dout, 1});
`else
            sb_q.push_back('{t_res[i], 3});
            model_dout = t_res[i];
`endif
            run_access(0, t_size[i], 1'b1, t_addr[i], 32'h0, t_rd1[i], t_rd2[i], 0, o);
`ifdef MISALIGN_TRAP_EN
            tests_run++;
            if (o.saw_req || o.err !== 1'b1) begin
                tests_failed++;
                $display("FAIL split_trap case %0d got bus_req_seen=%0d addr_err=%0d want 0 1", i, o.saw_req, o.err);
            end
`else
            tests_run++;
            if (o.a1 !== 32'h100 || o.e1 !== t_en1[i] || o.a2 !== 32'h104 || o.e2 !== 4'b0001 || o.beats != 2) begin
                tests_failed++;
                $display("FAIL split_beats case %0d got a1=%h e1=%b a2=%h e2=%b beats=%0d want 00000100 %b 00000104 0001 2",
                         i, o.a1, o.e1, o.a2, o.e2, o.beats, t_en1[i]);
            end
            tests_run++;
            if (o.err !== 1'b0 || !o.stall_ok) begin
                tests_failed++;
                $display("FAIL split_ctrl case %0d got addr_err=%0d stall_ok=%0d want 0 1", i, o.err, o.stall_ok);
            end
`endif
            e = sb_q.pop_front();
            tests_run++;
            if (o.lat != e.lat || o.dout !== e.dout) begin
                tests_failed++;
                $display("FAIL split_load case %0d got lat=%0d dout=%h want lat=%0d dout=%h", i, o.lat, o.dout, e.lat, e.dout);
            end
        end
    endtask

    task automatic test_wait_states();
        obs_t o;
        exp_t e;
        sb_q.push_back('{32'hFFFF8001, 5});
        model_dout = 32'hFFFF8001;
        run_access(0, 2'd1, 1, 32'h106, 32'h0, 32'h80011234, 32'h0, 3, o);
        tests_run++;
        if (o.a1 !== 32'h104 || o.e1 !== 4'b1100 || !o.bus_ok || !o.stall_ok) begin
            tests_failed++;
            $display("FAIL wait_hold got addr=%h en=%b bus_ok=%0d stall_ok=%0d want 00000104 1100 1 1",
                     o.a1, o.e1, o.bus_ok, o.stall_ok);
        end
        e = sb_q.pop_front();
        tests_run++;
        if (o.lat != e.lat || o.dout !== e.dout || !o.pulse_ok) begin
            tests_failed++;
            $display("FAIL wait_done got lat=%0d dout=%h pulse_ok=%0d want lat=%0d dout=%h pulse_ok=1",
                     o.lat, o.dout, o.pulse_ok, e.lat, e.dout);
        end
    endtask

    task automatic test_back_to_back();
        obs_t o;
        exp_t e;
        int size, off, nbytes, waits;
        bit sx;
        logic [31:0] rd, m, want;
        logic [3:0] en_want;
        for (int n = 0; n < 8; n++) begin
            size   = $urandom_range(0, 1);
            off    = (size == 1) ? $urandom_range(0, 2) : $urandom_range(0, 3);
            nbytes = 1 << size;
            sx     = 1'($urandom_range(0, 1));
            waits  = $urandom_range(0, 2);
            rd     = $urandom;
            m      = (32'd1 << (8 * nbytes)) - 32'd1;
            want   = (rd >> (8 * off)) & m;
            if (sx && want[8*nbytes-1]) want = want | ~m;
            en_want = 4'(((1 << nbytes) - 1) << off);
            sb_q.push_back('{want, 2 + waits});
            model_dout = want;
            run_access(0, 2'(size), sx, 32'h300 + 32'(off), 32'h0, rd, 32'h0, waits, o);
            tests_run++;
            if (o.e1 !== en_want || o.a1 !== 32'h300 || !o.bus_ok) begin
                tests_failed++;
                $display("FAIL b2b_bus #%0d got addr=%h en=%b bus_ok=%0d want 00000300 %b 1", n, o.a1, o.e1, o.bus_ok, en_want);
            end
            e = sb_q.pop_front();
            tests_run++;
            if (o.lat != e.lat || o.dout !== e.dout) begin
                tests_failed++;
                $display("FAIL b2b_load #%0d got lat=%0d dout=%h want lat=%0d dout=%h", n, o.lat, o.dout, e.lat, e.dout);
            end
        end
    endtask

    task automatic test_reset_mid_beat();
        obs_t o;
        exp_t e;
        bit split;
        bit quiet;
        logic [31:0] exp_a;
`ifdef MISALIGN_TRAP_EN
        split = 0;
`else
        split = 1;
`endif
        exp_a = split ? 32'h104 : 32'h100;
        @(negedge clk);
        req_M = 1; we_M = 1; size_M = 2'd2; sign_extend_en_M = 0;
        addr_M = split ? 32'h101 : 32'h100; write_data_M = 32'h11223344;
        @(negedge clk); #1;
        tests_run++;
        if (bus_req !== 1'b1) begin
            tests_failed++;
            $display("FAIL rst_beat1 bus_req got %b want 1", bus_req);
        end
        bus_ack = split;
        @(negedge clk); #1;
        bus_ack = 0;
        tests_run++;
        if (bus_req !== 1'b1 || bus_addr !== exp_a) begin
            tests_failed++;
            $display("FAIL rst_beat2 got bus_req=%b addr=%h want 1 %h", bus_req, bus_addr, exp_a);
        end
        reset_n = 0;
        #1;
        tests_run++;
        if (bus_req !== 1'b0 || stall_M !== 1'b0 || done_M !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_async got bus_req=%b stall=%b done=%b want 0 0 0", bus_req, stall_M, done_M);
        end
        req_M = 0;
        quiet = 1;
        repeat (3) begin
            @(negedge clk); #1;
            if (done_M !== 1'b0 || bus_req !== 1'b0) quiet = 0;
        end
        tests_run++;
        if (!quiet) begin
            tests_failed++;
            $display("FAIL rst_quiet got activity during reset want none");
        end
        reset_n = 1;
        model_dout = '0;
        sb_q.push_back('{32'hCAFEF00D, 2});
        model_dout = 32'hCAFEF00D;
        run_access(0, 2'd2, 0, 32'h200, 32'h0, 32'hCAFEF00D, 32'h0, 0, o);
        e = sb_q.pop_front();
        tests_run++;
        if (o.a1 !== 32'h200 || o.e1 !== 4'b1111 || o.lat != e.lat || o.dout !== e.dout) begin
            tests_failed++;
            $display("FAIL rst_recover got addr=%h en=%b lat=%0d dout=%h want 00000200 1111 %0d %h",
                     o.a1, o.e1, o.lat, o.dout, e.lat, e.dout);
        end
    endtask

    initial begin
        test_reset();
        test_aligned_store();
        test_byte_load();
        test_half_store();
        test_split_load();
        test_wait_states();
        test_back_to_back();
        test_reset_mid_beat();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish, %0d tests run, %0d failed", tests_run, tests_failed);
        $fatal(1, "watchdog");
    end

endmodule
